// File: rtl/elpis_mem_pkg.sv
// Shared memory-subsystem types and constants for the core/host SRAM path.
package elpis_mem_pkg;

    localparam int AW_DEF  = 9;
    localparam int DW_DEF  = 32;
    localparam int BE_W    = 4;

    // Bit positions of each requester in grant/response vectors
    localparam int N_PORTS = 3;
    localparam int PORT_IF = 0;
    localparam int PORT_D  = 1;
    localparam int PORT_H  = 2;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_IF   = 2'd1,
        OWNER_D    = 2'd2,
        OWNER_H    = 2'd3
    } owner_t;

endpackage

// File: rtl/sram_arb_prio.sv
// Combinational priority select: one-hot grant from three requests,
// honouring host lock and the fetch starvation override.
module sram_arb_prio
    import elpis_mem_pkg::*;
(
    input  logic               if_req,
    input  logic               d_req,
    input  logic               h_req,
    input  logic               starve,
    input  logic               lock,
    output logic [N_PORTS-1:0] gnt
);

    always_comb begin
        gnt = '0;
        if (lock) begin
            // Program-load mode: core ports invisible, starvation ignored
            gnt[PORT_H] = h_req;
        end else if (starve && if_req) begin
            gnt[PORT_IF] = 1'b1;
        end else if (h_req) begin
            gnt[PORT_H] = 1'b1;
        end else if (d_req) begin
            gnt[PORT_D] = 1'b1;
        end else if (if_req) begin
            gnt[PORT_IF] = 1'b1;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Three-port arbiter in front of the single-port program/data SRAM:
// same-cycle grant, one-cycle read return routed to the issuing port.
module sram_arbiter
    import elpis_mem_pkg::*;
#(
    parameter int AW           = AW_DEF,
    parameter int DW           = DW_DEF,
    parameter int STARVE_LIMIT = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            host_lock,

    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [DW-1:0]   if_rdata,

    input  logic            d_req,
    input  logic            d_we,
    input  logic [BE_W-1:0] d_be,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [DW-1:0]   d_rdata,

    input  logic            h_req,
    input  logic            h_we,
    input  logic [BE_W-1:0] h_be,
    input  logic [AW-1:0]   h_addr,
    input  logic [DW-1:0]   h_wdata,
    output logic            h_gnt,
    output logic            h_rvalid,
    output logic [DW-1:0]   h_rdata,

    output logic            sram_en,
    output logic            sram_we,
    output logic [BE_W-1:0] sram_be,
    output logic [AW-1:0]   sram_addr,
    output logic [DW-1:0]   sram_wdata,
    input  logic [DW-1:0]   sram_rdata
);

    localparam int SW = $clog2(STARVE_LIMIT) + 1;

    logic [SW-1:0]      starve_cnt_reg, starve_cnt_next;
    owner_t             owner_reg, owner_next;
    logic [N_PORTS-1:0] req_vec;
    logic [N_PORTS-1:0] gnt;
    logic               starve_flag;
    logic [N_PORTS-1:0] rvalid_vec;
    logic [DW-1:0]      rdata_arr [N_PORTS];

    // Requests are gated by reset so nothing reaches the SRAM while held in reset
    always_comb begin
        req_vec          = '0;
        req_vec[PORT_IF] = if_req & rst_n;
        req_vec[PORT_D]  = d_req  & rst_n;
        req_vec[PORT_H]  = h_req  & rst_n;
    end

    assign starve_flag = (starve_cnt_reg >= SW'(STARVE_LIMIT));

    sram_arb_prio u_prio (
        .if_req (req_vec[PORT_IF]),
        .d_req  (req_vec[PORT_D]),
        .h_req  (req_vec[PORT_H]),
        .starve (starve_flag),
        .lock   (host_lock),
        .gnt    (gnt)
    );

    assign if_gnt  = gnt[PORT_IF];
    assign d_gnt   = gnt[PORT_D];
    assign h_gnt   = gnt[PORT_H];
    assign sram_en = |gnt;

    always_comb begin
        sram_we    = 1'b0;
        sram_be    = '0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (gnt[PORT_H]) begin
            sram_we    = h_we;
            sram_be    = h_be;
            sram_addr  = h_addr;
            sram_wdata = h_wdata;
        end else if (gnt[PORT_D]) begin
            sram_we    = d_we;
            sram_be    = d_be;
            sram_addr  = d_addr;
            sram_wdata = d_wdata;
        end else if (gnt[PORT_IF]) begin
            sram_addr  = if_addr;
        end
    end

    // Lock freezes the counter so a fetch pending across program load keeps its credit
    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (!host_lock) begin
            if (!if_req || gnt[PORT_IF]) begin
                starve_cnt_next = '0;
            end else if (starve_cnt_reg != {SW{1'b1}}) begin
                starve_cnt_next = starve_cnt_reg + 1'b1;
            end
        end
    end

    always_comb begin
        owner_next = OWNER_NONE;
        if (gnt[PORT_IF]) begin
            owner_next = OWNER_IF;
        end else if (gnt[PORT_D] && !d_we) begin
            owner_next = OWNER_D;
        end else if (gnt[PORT_H] && !h_we) begin
            owner_next = OWNER_H;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner_reg      <= OWNER_NONE;
            starve_cnt_reg <= '0;
        end else begin
            owner_reg      <= owner_next;
            starve_cnt_reg <= starve_cnt_next;
        end
    end

    always_comb begin
        rvalid_vec          = '0;
        rvalid_vec[PORT_IF] = (owner_reg == OWNER_IF);
        rvalid_vec[PORT_D]  = (owner_reg == OWNER_D);
        rvalid_vec[PORT_H]  = (owner_reg == OWNER_H);
    end

    generate
        for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_resp
            assign rdata_arr[gi] = rvalid_vec[gi] ? sram_rdata : '0;
        end
    endgenerate

    assign if_rvalid = rvalid_vec[PORT_IF];
    assign d_rvalid  = rvalid_vec[PORT_D];
    assign h_rvalid  = rvalid_vec[PORT_H];
    assign if_rdata  = rdata_arr[PORT_IF];
    assign d_rdata   = rdata_arr[PORT_D];
    assign h_rdata   = rdata_arr[PORT_H];

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Three-port arbiter sharing the single-port `custom_sram` (512 x 32, one-cycle read latency) between the core's instruction-fetch port, the core's data port, and the Wishbone host port of the user project. It grants at most one SRAM access per cycle. It routes read data back to the requester that issued the read. A starvation guard stops instruction fetch being locked out indefinitely, and a host-lock mode gives the host exclusive access while it loads a program.

## Interface
- `AW`, 9: word-address width (512 words).
- `DW`, 32: data width.
- `STARVE_LIMIT`, 8: consecutive denied cycles after which a pending instruction fetch takes top priority.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `host_lock`  in  1  when 1, only the host port is granted.
- `if_req`  in  1  instruction-fetch read request.
- `if_addr`  in  AW  fetch word address.
- `if_gnt`  out  1  fetch accepted this cycle.
- `if_rvalid`  out  1  fetch data valid.
- `if_rdata`  out  DW  fetch data.
- `d_req`  in  1  data request.
- `d_we`  in  1  1 = write.
- `d_be`  in  4  byte enables.
- `d_addr`  in  AW  data word address.
- `d_wdata`  in  DW  write data.
- `d_gnt`  out  1  data request accepted.
- `d_rvalid`  out  1  data read valid.
- `d_rdata`  out  DW  read data.
- `h_req`, `h_we`, `h_be`, `h_addr`, `h_wdata`: host request fields, with the same widths and meanings as the `d_` fields.
- `h_gnt`, `h_rvalid`, `h_rdata`: host response, with the same widths and meanings as the `d_` responses.
- `sram_en`  out  1  SRAM access enable.
- `sram_we`  out  1  SRAM write.
- `sram_be`  out  4  SRAM byte enables.
- `sram_addr`  out  AW  SRAM address.
- `sram_wdata`  out  DW  SRAM write data.
- `sram_rdata`  in  DW  SRAM read data, valid the cycle after a read enable.

## Operation
- **Grant (combinational, same cycle as request).**
  - At most one of `if_gnt`, `d_gnt`, `h_gnt` is high per cycle.
  - `sram_en` = OR of the grants.
  - The SRAM bus is muxed from the granted port. When nothing is granted, all SRAM outputs are 0.
- **Priority.**
  - Normal priority is host > data > fetch.
  - When `starve_cnt` >= `STARVE_LIMIT` and `if_req` = 1, the order becomes fetch > host > data.
  - `host_lock` = 1 masks `if_req` and `d_req` completely. The starvation guard is ignored while locked.
- **Starvation counter.**
  - `starve_cnt` is a saturating counter, width clog2(`STARVE_LIMIT`)+1.
  - Increments when `if_req` & !`if_gnt` & !`host_lock`.
  - Clears when `if_gnt` = 1 or `if_req` = 0.
  - Holds its value while `host_lock` = 1.
- **Read return.**
  - A granted read (`we` = 0) sets a registered `owner` field, encoded NONE / IF / D / H.
  - In the next cycle, `<owner>_rvalid` = 1 and `<owner>_rdata` = `sram_rdata`.
  - The `rdata` of the other ports is 0.
- **Writes.** A granted write produces no `rvalid`. Byte enables pass straight through to the SRAM.
- **Requester rule.** A requester holds its request fields stable until it sees `gnt`. It may drop `req` before `gnt` (the request is withdrawn, with no side effects).

## Timing
- **Reset** (`rst_n` = 0 at a rising edge):
  - `owner` = NONE and `starve_cnt` = 0.
  - All `rvalid` outputs are 0 from the next cycle.
  - Grants stay combinational, but are forced to 0 while `rst_n` = 0.
- **Reset during a read.** A read granted in the cycle reset is asserted returns no `rvalid`.
- **Read latency.** Exactly 1 cycle from grant to `rvalid`.
- **Throughput.** One access per cycle. Back-to-back reads from different ports return in grant order.
- **Write followed by read.** A write in cycle N followed by a read of the same address in cycle N+1 returns the new data. This is SRAM behaviour; the arbiter adds no bypass.
- **Host lock edges.**
  - Asserting `host_lock` while a read is outstanding still delivers that read's `rvalid`.
  - Deasserting `host_lock` takes effect on the same cycle's arbitration.

## Structure
- **Shared package `elpis_mem_pkg`:**
  - the `owner_t` enum (NONE, IF, D, H);
  - the `AW`/`DW` defaults;
  - the byte-enable width constant.
- **Sub-module `sram_arb_prio`:** purely combinational. It takes three requests plus the starve and lock flags and returns a one-hot grant.
- **Top level:** the starvation counter, the `owner` register, the SRAM mux and the response demux.

## Test plan
- **Reset values.** Hold `rst_n` = 0 for 3 cycles with all requests high -> all grants 0 and all `rvalid` 0.
- **Simultaneous requests.** `h_req`, `d_req` and `if_req` high in the same cycle, each a read of a distinct address preloaded with 0xA, 0xB, 0xC -> `h_gnt` first, then `d_gnt`, then `if_gnt`. Each `rvalid` arrives 1 cycle after its grant, with the correct data.
- **Starvation.** Keep `d_req` high continuously with `if_req` high -> fetch is denied for 8 cycles, then `if_gnt` = 1 in the 9th cycle and `starve_cnt` returns to 0.
- **Byte-enable write.** Data write to address 5 with data 0xDEADBEEF and `d_be` = 4'b0011 over an initial value of 0 -> a following read of address 5 returns 0x0000BEEF on `d_rvalid`.
- **Host lock.** `host_lock` = 1 with a host write of 0x00000013 to address 0 and fetch/data requests pending -> only `h_gnt` is asserted. After `host_lock` drops, a fetch from address 0 returns 0x00000013.
- **Reset during a read.** A read is granted in cycle N and `rst_n` = 0 in cycle N -> no `rvalid` in cycle N+1 and `owner` = NONE.
